// File: rtl/t05_sram_responder.sv
// SRAM responder: single-word read/write with programmable wait states and byte enables.
// Optional power-up zero sweep enabled by defining T05_SRAM_RESP_CLEAR_EN.
module t05_sram_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        r_en,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  input  logic [3:0]  select,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

`ifdef T05_SRAM_RESP_CLEAR_EN
  localparam state_t RESET_STATE = S_CLEAR;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      sel_q, sel_d;
  logic            is_wr_q, is_wr_d;
  logic            oor_q, oor_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;

  logic            mem_we;
  logic [AW-1:0]   mem_widx;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_wsel;
  logic            rd_fire;
  wire  [31:0]     rd_word;

  logic            unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    is_wr_d   = is_wr_q;
    oor_d     = oor_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    clr_idx_d = clr_idx_q;
    mem_we    = 1'b0;
    mem_widx  = idx_q;
    mem_wdata = wdata_q;
    mem_wsel  = sel_q;
    rd_fire   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_en ^ r_en) begin
          idx_d   = addr[AW+1:2];
          wdata_d = data_i;
          sel_d   = select;
          is_wr_d = wr_en;
          oor_d   = (addr[31:2] >= 30'(DEPTH));
          cnt_d   = CW'(LATENCY - 1);
          state_d = S_WAIT;
        end else if (wr_en && r_en) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = oor_q;
          if (is_wr_q) begin
            mem_we = ~oor_q;
          end else begin
            rd_fire = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef T05_SRAM_RESP_CLEAR_EN
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = clr_idx_q;
        mem_wdata = 32'h0;
        mem_wsel  = 4'hF;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(DEPTH - 1)) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Reset aborts whatever completes on this edge, so nothing may be committed.
    if (rst) begin
      mem_we  = 1'b0;
      rd_fire = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      is_wr_q   <= 1'b0;
      oor_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      is_wr_q   <= is_wr_d;
      oor_q     <= oor_d;
      done_q    <= done_d;
      err_q     <= err_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // One RAM per byte lane keeps byte-enable writes free of read-modify-write.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (mem_we && mem_wsel[gi]) begin
          mem_lane[mem_widx] <= mem_wdata[8*gi +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q <= 8'h0;
        end else if (rd_fire) begin
          rd_q <= oor_q ? 8'h0 : mem_lane[idx_q];
        end
      end

      assign rd_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  assign data_o = rd_word;
  assign busy_o = (state_q != S_IDLE);
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_t05_sram_responder.sv
// Directed table-driven bench for t05_sram_responder (DEPTH=256, LATENCY=2, default build).
module tb_t05_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        r_en;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [3:0]  select;
  logic [31:0] data_o;
  logic        busy_o;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  t05_sram_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .r_en   (r_en),
    .addr   (addr),
    .data_i (data_i),
    .select (select),
    .data_o (data_o),
    .busy_o (busy_o),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  sel;
    int          exp_busy;
    bit          exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit wr, input bit rd, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] sel,
                              input int eb, input bit ee, input logic [31:0] ed);
    vec_t v;
    v.wr = wr; v.rd = rd; v.a = a; v.d = d; v.sel = sel;
    v.exp_busy = eb; v.exp_err = ee; v.exp_data = ed;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int n);
    int          busy_cnt;
    bit          seen;
    logic        e_at;
    logic [31:0] d_at;
    @(negedge clk);
    wr_en = v.wr; r_en = v.rd; addr = v.a; data_i = v.d; select = v.sel;
    @(posedge clk); #1;
    // scramble the request fields while the access is in flight
    wr_en = 1'b0; r_en = 1'b0; addr = ~v.a; data_i = ~v.d; select = ~v.sel;
    busy_cnt = 0; seen = 1'b0; e_at = 1'b0; d_at = 32'h0;
    for (int k = 0; k < 16 && !seen; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (busy_o) busy_cnt++;
      if (done) begin
        seen = 1'b1; e_at = err; d_at = data_o;
      end
    end
    check($sformatf("v%0d done_seen", n), 32'(seen), 32'd1);
    check($sformatf("v%0d busy_cycles", n), 32'(busy_cnt), 32'(v.exp_busy));
    check($sformatf("v%0d err", n), 32'(e_at), 32'(v.exp_err));
    check($sformatf("v%0d data_o", n), d_at, v.exp_data);
    @(posedge clk); #1;
    check($sformatf("v%0d pulse_end", n), {30'h0, done, err}, 32'h0);
    $display("vec %0d wr=%0d rd=%0d addr=%08h data=%08h sel=%h -> busy=%0d err=%0d data_o=%08h",
             n, v.wr, v.rd, v.a, v.d, v.sel, busy_cnt, e_at, d_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_done;
    int second_done;
    int pulses;
    logic [31:0] d_second;

    vecs.push_back(mk(1, 0, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 2, 0, 32'h0000_0000));
    vecs.push_back(mk(1, 0, 32'h0000_0028, 32'h0000_0007, 4'hF, 2, 0, 32'h0000_0000));
    vecs.push_back(mk(0, 1, 32'h0000_0028, 32'h0,         4'h0, 2, 0, 32'h0000_0007));
    vecs.push_back(mk(1, 0, 32'h0000_0040, 32'h1122_3344, 4'hF, 2, 0, 32'h0000_0007));
    vecs.push_back(mk(1, 0, 32'h0000_0040, 32'hAABB_CCDD, 4'h5, 2, 0, 32'h0000_0007));
    vecs.push_back(mk(0, 1, 32'h0000_0040, 32'h0,         4'h0, 2, 0, 32'h11BB_33DD));
    vecs.push_back(mk(1, 0, 32'h0000_0010, 32'h1234_5678, 4'hF, 2, 0, 32'h11BB_33DD));
    vecs.push_back(mk(0, 1, 32'h0000_0010, 32'h0,         4'h0, 2, 0, 32'h1234_5678));
    vecs.push_back(mk(1, 1, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF, 0, 1, 32'h1234_5678));
    vecs.push_back(mk(0, 1, 32'h0000_0010, 32'h0,         4'h0, 2, 0, 32'h1234_5678));
    vecs.push_back(mk(0, 1, 32'h0000_0400, 32'h0,         4'h0, 2, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 0, 32'h0000_0400, 32'hCAFE_F00D, 4'hF, 2, 1, 32'h0000_0000));
    vecs.push_back(mk(0, 1, 32'h0000_0000, 32'h0,         4'h0, 2, 0, 32'hA5A5_A5A5));
    vecs.push_back(mk(1, 0, 32'h0000_0044, 32'h0102_0304, 4'hF, 2, 0, 32'hA5A5_A5A5));
    vecs.push_back(mk(1, 0, 32'h0000_0044, 32'hFFFF_FFFF, 4'h0, 2, 0, 32'hA5A5_A5A5));
    vecs.push_back(mk(0, 1, 32'h0000_0044, 32'h0,         4'h0, 2, 0, 32'h0102_0304));
    vecs.push_back(mk(0, 1, 32'h0000_002B, 32'h0,         4'h0, 2, 0, 32'h0000_0007));
    vecs.push_back(mk(1, 0, 32'h0000_03FC, 32'h0BAD_CAFE, 4'hF, 2, 0, 32'h0000_0007));
    vecs.push_back(mk(0, 1, 32'h0000_03FC, 32'h0,         4'h0, 2, 0, 32'h0BAD_CAFE));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 32'h0,         4'h0, 2, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 0, 32'h0000_0008, 32'h0000_0005, 4'hF, 2, 0, 32'h0000_0000));
    vecs.push_back(mk(0, 1, 32'h0000_0008, 32'h0,         4'h0, 2, 0, 32'h0000_0005));

    rst = 1'b1; wr_en = 1'b0; r_en = 1'b0; addr = 32'h0; data_i = 32'h0; select = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset data_o", data_o, 32'h0);
    check("reset busy_o", 32'(busy_o), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset err", 32'(err), 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i], i);

    // back-to-back: read held high through completion
    first_done = -1; second_done = -1; d_second = 32'h0;
    @(negedge clk);
    r_en = 1'b1; addr = 32'h0000_0028;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first_done < 0) first_done = k;
        else if (second_done < 0) begin
          second_done = k; d_second = data_o;
        end
      end
    end
    @(negedge clk);
    r_en = 1'b0;
    check("b2b done_gap", 32'(second_done - first_done), 32'd3);
    check("b2b data_o", d_second, 32'h0000_0007);
    $display("b2b first_done=%0d second_done=%0d data_o=%08h", first_done, second_done, d_second);
    for (int k = 0; k < 10 && busy_o; k++) @(negedge clk);
    check("b2b drained", 32'(busy_o), 32'h0);
    @(negedge clk);

    // reset one cycle after a write is accepted
    wr_en = 1'b1; addr = 32'h0000_0008; data_i = 32'hDEAD_BEEF; select = 4'hF;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("rst_abort accepted busy", 32'(busy_o), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_abort data_o", data_o, 32'h0);
    check("rst_abort busy_o", 32'(busy_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("rst_abort no_done", 32'(pulses), 32'h0);
    $display("rst_abort data_o=%08h done_pulses=%0d", data_o, pulses);
    apply(mk(0, 1, 32'h0000_0008, 32'h0, 4'h0, 2, 0, 32'h0000_0005), 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
